// File: rtl/path_resp_misr_pkg.sv
// Shared types and the MISR step function for the path response compactor.
// Used by the RTL and by the bench's reference model.
package path_resp_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;

  // Width-generic step (w <= 32); bits above w are zero in the result.
  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic b,
                                            input logic [31:0] poly, input int w);
    logic [31:0] m;
    logic [31:0] r;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r = (sig << 1) ^ (sig[w-1] ? poly : 32'd0) ^ {31'd0, b};
    return r & m;
  endfunction

endpackage

// File: rtl/path_resp_misr_if.sv
// Handshake/result bundle for path_resp_misr.
// PATH_RESP_FAIL_CAPTURE_EN adds the per-pattern golden bit and capture outputs.
interface path_resp_if #(parameter int SIG_W = 16, parameter int CNT_W = 7);
  logic             start;
  logic             abort;
  logic             resp_valid;
  logic             resp_bit;
  logic [SIG_W-1:0] exp_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] pat_cnt;
`ifdef PATH_RESP_FAIL_CAPTURE_EN
  logic             exp_bit;
  logic             fail_vld;
  logic [CNT_W-1:0] fail_idx;

  modport master (output start, abort, resp_valid, resp_bit, exp_sig, exp_bit,
                  input  busy, done, pass, signature, pat_cnt, fail_vld, fail_idx);
  modport slave  (input  start, abort, resp_valid, resp_bit, exp_sig, exp_bit,
                  output busy, done, pass, signature, pat_cnt, fail_vld, fail_idx);
`else
  modport master (output start, abort, resp_valid, resp_bit, exp_sig,
                  input  busy, done, pass, signature, pat_cnt);
  modport slave  (input  start, abort, resp_valid, resp_bit, exp_sig,
                  output busy, done, pass, signature, pat_cnt);
`endif
endinterface

// File: rtl/path_resp_misr_lfsr.sv
// Serial-input signature register with synchronous seed load and enable.
// nxt is the value the register takes on an enabled cycle.
module path_resp_lfsr
  import path_resp_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] nxt
);

  always_comb nxt = SIG_W'(misr_step(32'(sig), din, 32'(POLY), SIG_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sig <= SEED;
    else if (load) sig <= SEED;
    else if (en)   sig <= nxt;
  end

endmodule

// File: rtl/path_resp_misr.sv
// Path response MISR: folds NUM_PAT valid responses into a signature and
// registers a pass/fail verdict. Optional: PATH_RESP_FAIL_CAPTURE_EN.
module path_resp_misr
  import path_resp_pkg::*;
#(
  parameter int               SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED    = DEF_SEED,
  parameter int               NUM_PAT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  path_resp_if.slave  bus
);

  localparam int CNT_W = $clog2(NUM_PAT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PAT - 1);

  state_t           state;
  logic [CNT_W-1:0] pat_cnt;
  logic             busy, done, pass;
  logic             load, absorb;
  logic [SIG_W-1:0] sig, sig_nxt;

  // abort wins over both the reload and the absorb of a response.
  assign load   = !bus.abort && bus.start && (state != ST_RUN);
  assign absorb = !bus.abort && bus.resp_valid && (state == ST_RUN);

  path_resp_lfsr #(.SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)) u_lfsr (
    .clk, .rst_n, .load, .en(absorb), .din(bus.resp_bit), .sig, .nxt(sig_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE; pat_cnt <= '0; busy <= 1'b0; done <= 1'b0; pass <= 1'b0;
    end else if (bus.abort) begin
      state <= ST_IDLE; busy <= 1'b0; done <= 1'b0; pass <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (bus.start) begin
          state <= ST_RUN; pat_cnt <= '0; busy <= 1'b1; done <= 1'b0; pass <= 1'b0;
        end
        ST_RUN: if (bus.resp_valid) begin
          pat_cnt <= pat_cnt + 1'b1;
          if (pat_cnt == LAST) begin
            state <= ST_DONE; busy <= 1'b0; done <= 1'b1;
            pass  <= (sig_nxt == bus.exp_sig);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.signature = sig;
  assign bus.pat_cnt   = pat_cnt;

`ifdef PATH_RESP_FAIL_CAPTURE_EN
  logic             fail_vld;
  logic [CNT_W-1:0] fail_idx;

  // Only the first mismatch of a run is recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || 1'b0) begin
      fail_vld <= 1'b0; fail_idx <= '0;
    end else if (bus.abort || load) begin
      fail_vld <= 1'b0; fail_idx <= '0;
    end else if (absorb && (bus.resp_bit != bus.exp_bit) && !fail_vld) begin
      fail_vld <= 1'b1; fail_idx <= pat_cnt;
    end
  end

  assign bus.fail_vld = fail_vld;
  assign bus.fail_idx = fail_idx;
`endif

endmodule

// File: tb/tb_path_resp_misr.sv
// Directed bench for path_resp_misr: table of single-pattern runs plus
// hand sequences for stall, abort, async reset and a 64-pattern run.
module tb_path_resp_misr;
  import path_resp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  path_resp_if #(.SIG_W(16), .CNT_W(1)) i1 ();
  path_resp_if #(.SIG_W(16), .CNT_W(2)) i2 ();
  path_resp_if #(.SIG_W(16), .CNT_W(7)) i64 ();

  path_resp_misr #(.NUM_PAT(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  path_resp_misr #(.NUM_PAT(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  path_resp_misr #(.NUM_PAT(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(i64.slave));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rb;
    logic [15:0] es;
    logic [15:0] sig;
    logic        ps;
  } vec_t;

  vec_t        vt [4];
  logic [63:0] bits;
  logic [15:0] model;

  initial begin
    vt[0] = '{rb: 1'b0, es: 16'hEFDF, sig: 16'hEFDF, ps: 1'b1};
    vt[1] = '{rb: 1'b1, es: 16'hEFDF, sig: 16'hEFDE, ps: 1'b0};
    vt[2] = '{rb: 1'b1, es: 16'hEFDE, sig: 16'hEFDE, ps: 1'b1};
    vt[3] = '{rb: 1'b0, es: 16'h0000, sig: 16'hEFDF, ps: 1'b0};

    {i1.start, i1.abort, i1.resp_valid, i1.resp_bit} = '0;  i1.exp_sig = '0;
    {i2.start, i2.abort, i2.resp_valid, i2.resp_bit} = '0;  i2.exp_sig = '0;
    {i64.start, i64.abort, i64.resp_valid, i64.resp_bit} = '0; i64.exp_sig = '0;
`ifdef PATH_RESP_FAIL_CAPTURE_EN
    i1.exp_bit = 1'b0; i2.exp_bit = 1'b0; i64.exp_bit = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sig",  32'(i1.signature), 32'hFFFF);
    chk("rst_cnt",  32'(i1.pat_cnt), 0);
    chk("rst_flags", {29'd0, i1.busy, i1.done, i1.pass}, 0);
    rst_n = 1'b1;

    // NUM_PAT=1 table
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) i1.start = 1'b1;
      @(negedge clk) i1.start = 1'b0;
      chk("t_busy", 32'(i1.busy), 1);
      chk("t_pass_run", 32'(i1.pass), 0);
      i1.resp_valid = 1'b1; i1.resp_bit = vt[k].rb; i1.exp_sig = vt[k].es;
      @(negedge clk) i1.resp_valid = 1'b0;
      chk("t_sig",  32'(i1.signature), 32'(vt[k].sig));
      chk("t_done", 32'(i1.done), 1);
      chk("t_pass", 32'(i1.pass), 32'(vt[k].ps));
      chk("t_cnt",  32'(i1.pat_cnt), 1);
      chk("t_busy_done", 32'(i1.busy), 0);
    end

    // NUM_PAT=2 with a 3-cycle stall and an ignored start in RUN
    @(negedge clk) i2.start = 1'b1;
    @(negedge clk) i2.start = 1'b0; i2.resp_valid = 1'b1; i2.resp_bit = 1'b0;
    @(negedge clk) i2.resp_valid = 1'b0;
    chk("st_sig1", 32'(i2.signature), 32'hEFDF);
    chk("st_cnt1", 32'(i2.pat_cnt), 1);
    i2.start = 1'b1;
    @(negedge clk) i2.start = 1'b0;
    chk("st_cnt_hold", 32'(i2.pat_cnt), 1);
    chk("st_busy", 32'(i2.busy), 1);
    @(negedge clk) chk("st_done0a", 32'(i2.done), 0);
    @(negedge clk) chk("st_done0b", 32'(i2.done), 0);
    chk("st_cnt_hold2", 32'(i2.pat_cnt), 1);
    i2.resp_valid = 1'b1; i2.resp_bit = 1'b0; i2.exp_sig = 16'hCF9F;
    @(negedge clk) i2.resp_valid = 1'b0;
    chk("st_sig2", 32'(i2.signature), 32'hCF9F);
    chk("st_done", 32'(i2.done), 1);
    chk("st_pass", 32'(i2.pass), 1);
    chk("st_cnt2", 32'(i2.pat_cnt), 2);

    // abort coincident with the final response
    @(negedge clk) i2.start = 1'b1;
    @(negedge clk) i2.start = 1'b0; i2.resp_valid = 1'b1; i2.resp_bit = 1'b0;
    @(negedge clk) i2.abort = 1'b1; i2.exp_sig = 16'hCF9F;
    @(negedge clk) i2.abort = 1'b0; i2.resp_valid = 1'b0;
    chk("ab_flags", {29'd0, i2.busy, i2.done, i2.pass}, 0);
    chk("ab_sig_kept", 32'(i2.signature), 32'hEFDF);
    chk("ab_cnt_kept", 32'(i2.pat_cnt), 1);
    i2.start = 1'b1;
    @(negedge clk) i2.start = 1'b0;
    chk("ab_reload", 32'(i2.signature), 32'hFFFF);
    chk("ab_cnt0", 32'(i2.pat_cnt), 0);
    chk("ab_busy", 32'(i2.busy), 1);
    i2.abort = 1'b1;
    @(negedge clk) i2.abort = 1'b0;

    // NUM_PAT=64: async reset at pat_cnt=30
    bits = 64'hA5C3_0F96_3C5A_E781;
    @(negedge clk) i64.start = 1'b1;
    @(negedge clk) i64.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      i64.resp_valid = 1'b1; i64.resp_bit = bits[i];
`ifdef PATH_RESP_FAIL_CAPTURE_EN
      i64.exp_bit = ~bits[i];
`endif
      @(negedge clk);
    end
    i64.resp_valid = 1'b0;
    chk("rr_cnt30", 32'(i64.pat_cnt), 30);
    chk("rr_busy", 32'(i64.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_sig", 32'(i64.signature), 32'hFFFF);
    chk("rr_cnt", 32'(i64.pat_cnt), 0);
    chk("rr_flags", {29'd0, i64.busy, i64.done, i64.pass}, 0);
`ifdef PATH_RESP_FAIL_CAPTURE_EN
    chk("rr_fail_vld", 32'(i64.fail_vld), 0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Full 64-pattern run against the package model
    model = 16'hFFFF;
    for (int i = 0; i < 64; i++) model = 16'(misr_step(32'(model), bits[i], 32'h1021, 16));
    @(negedge clk) i64.start = 1'b1;
    @(negedge clk) i64.start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      i64.resp_valid = 1'b1; i64.resp_bit = bits[i];
      i64.exp_sig = (i == 63) ? model : 16'h0000;
`ifdef PATH_RESP_FAIL_CAPTURE_EN
      i64.exp_bit = bits[i] ^ ((i == 5) || (i == 9));
`endif
      @(negedge clk);
      if (i == 31) chk("f_done_mid", 32'(i64.done), 0);
    end
    chk("f_sig",  32'(i64.signature), 32'(model));
    chk("f_done", 32'(i64.done), 1);
    chk("f_pass", 32'(i64.pass), 1);
    chk("f_cnt",  32'(i64.pat_cnt), 64);
    chk("f_busy", 32'(i64.busy), 0);
`ifdef PATH_RESP_FAIL_CAPTURE_EN
    chk("f_fail_vld", 32'(i64.fail_vld), 1);
    chk("f_fail_idx", 32'(i64.fail_idx), 5);
`endif
    // resp_valid still high in DONE must not move anything
    @(negedge clk) i64.resp_valid = 1'b0;
    chk("f_hold_sig",  32'(i64.signature), 32'(model));
    chk("f_hold_cnt",  32'(i64.pat_cnt), 64);
    chk("f_hold_done", 32'(i64.done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/path_resp_misr.md
Name: path_resp_misr

Overview:
- Downstream response compactor for the single-path ATPG netlists.
- Consumes the path's one-bit primary output (e.g. N2892) once per applied pattern.
- Folds NUM_PAT responses into a SIG_W-bit serial-input signature register and compares the result against a golden signature.
- Gives the test bench one pass/fail verdict per pattern run instead of a per-pattern compare.

Parameters:
- SIG_W, 16, signature register width (>=4).
- POLY, 16'h1021, feedback polynomial taps (bit i set = tap at bit i); width SIG_W.
- SEED, 16'hFFFF, signature value loaded on start; width SIG_W.
- NUM_PAT, 64, number of valid responses compacted per run (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin run; sampled only in IDLE or DONE.
- abort  in  1  cancel run; return to IDLE.
- resp_valid  in  1  resp_bit is a valid path response this cycle.
- resp_bit  in  1  path output under test.
- exp_sig  in  SIG_W  golden signature; sampled on the cycle the last response is absorbed.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until the next start or abort.
- pass  out  1  signature == exp_sig; valid while done=1, else 0.
- signature  out  SIG_W  current signature register.
- pat_cnt  out  $clog2(NUM_PAT+1)  responses absorbed in the current run.

Behaviour:
- Reset (async, rst_n=0) forces: state=IDLE, signature=SEED, pat_cnt=0, busy=0, done=0, pass=0.
- States:
  - IDLE: start -> load signature=SEED, pat_cnt=0, go RUN next cycle. resp_valid is ignored.
  - RUN: busy=1. Each cycle with resp_valid=1:
    - sig_next = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ {{SIG_W-1{1'b0}}, resp_bit}.
    - pat_cnt increments.
    - When pat_cnt==NUM_PAT-1 and resp_valid=1: absorb the bit, register pass=(sig_next==exp_sig), go DONE.
  - DONE: done=1, signature and pass frozen. start -> reload SEED, clear pat_cnt and pass, go RUN. resp_valid is ignored.
- Latency:
  - done and pass rise one cycle after the final valid response.
  - Signature updates are visible the cycle after each valid response.
- Stalls: resp_valid=0 in RUN holds all state; there is no timeout.
- start while in RUN is ignored.
- abort, in any state, goes to IDLE next cycle; clears busy/done/pass; keeps signature and pat_cnt for debug. abort has priority over start and resp_valid in the same cycle.
- Async reset mid-run discards the run entirely.
- pat_cnt never exceeds NUM_PAT; there is no wrap.
- NUM_PAT=1: RUN lasts exactly until the first valid response.

Optional Feature:
- Macro: PATH_RESP_FAIL_CAPTURE_EN.
- When defined, extra ports are added:
  - exp_bit in 1: per-pattern golden response, qualified by resp_valid.
  - fail_vld out 1: a mismatch has been captured.
  - fail_idx out $clog2(NUM_PAT+1): pattern index of the mismatch.
- On the first resp_valid cycle in RUN where resp_bit!=exp_bit:
  - fail_vld is set (sticky); fail_idx takes the pat_cnt value before the increment.
  - Later mismatches do not update fail_idx.
- fail_vld and fail_idx clear on reset, start and abort.
- Signature and pass behaviour are unchanged.
- When undefined: those ports and registers do not exist.

Decomposition:
- Package path_resp_pkg holds:
  - the state enum (ST_IDLE, ST_RUN, ST_DONE);
  - default POLY/SEED localparams;
  - a function misr_step(sig, bit) shared by RTL and the bench model.
- One sub-module, path_resp_lfsr, is the signature register with load/enable. The controller FSM and counter live in the top.

Test Plan:
- Reset then start, NUM_PAT=1, resp_bit=0 valid -> signature=16'hEFDF, done=1 next cycle; exp_sig=16'hEFDF gives pass=1.
- NUM_PAT=1, resp_bit=1 -> signature=16'hEFDE; exp_sig=16'hEFDF gives pass=0.
- NUM_PAT=2, two zero responses separated by 3 idle resp_valid=0 cycles -> signature=16'hCF9F; pat_cnt holds at 1 during the stall; done only after the second response.
- abort asserted in the same cycle as the final valid response -> IDLE next cycle, done=0, pass=0. A following start reloads 16'hFFFF.
- rst_n pulsed low mid-RUN (pat_cnt=30) -> outputs asynchronously return to reset values; start re-runs cleanly to a signature matching the package model.
- With PATH_RESP_FAIL_CAPTURE_EN, NUM_PAT=64, mismatches injected at indices 5 and 9 -> fail_vld=1, fail_idx=5 at done.
